// File: rtl/conv_fetch.sv
// Window-fetch sequencer for the 3x3 convolution MAC: raster-scans a 64x64 image,
// fetches the in-range neighbours of each window column-major and strobes results.
module conv_fetch #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [11:0]       iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] pi0,
  output logic [DATA_W-1:0] pi1,
  output logic [DATA_W-1:0] pi2,
  output logic [3:0]        cnt_pixel,
  output logic [5:0]        cnt_length,
  output logic [5:0]        cnt_width,
  output logic              flag_corner,
  output logic              flag_upbot,
  output logic              flag_lfri,
  output logic              conv_valid,
  output logic [11:0]       caddr,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for ready; also the cycle carrying the final strobe (busy still 1)
  // FETCH | one in-range neighbour fetched and captured per cycle
  // HOLD  | all pixels captured; position held so the MAC registers its last group
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t     state;
  logic [1:0] kr, kc;    // kernel row/column offset of the pixel at iaddr (0..2)
  logic [1:0] sel;       // pixel slot for the next capture
  logic [1:0] r_lo, r_hi, c_hi;
  logic [1:0] nkr, nkc;
  logic       edge_r, edge_c, last_pix, last_win;
  logic [5:0] ny, nx;

  function automatic logic [11:0] addr_of(input logic [5:0] y, input logic [5:0] x,
                                          input logic [1:0] r, input logic [1:0] c);
    logic [5:0] ay, ax;
    ay = y + {4'b0, r} - 6'd1;
    ax = x + {4'b0, c} - 6'd1;
    return {ay, ax};
  endfunction

  assign edge_r      = (cnt_length == 6'd0) || (cnt_length == 6'd63);
  assign edge_c      = (cnt_width == 6'd0) || (cnt_width == 6'd63);
  assign flag_corner = edge_r & edge_c;
  assign flag_upbot  = edge_r & ~edge_c;
  assign flag_lfri   = edge_c & ~edge_r;

  assign r_lo = (cnt_length == 6'd0)  ? 2'd1 : 2'd0;
  assign r_hi = (cnt_length == 6'd63) ? 2'd1 : 2'd2;
  assign c_hi = (cnt_width == 6'd63)  ? 2'd1 : 2'd2;

  assign last_pix = (kr == r_hi) && (kc == c_hi);
  assign last_win = (cnt_length == 6'd63) && (cnt_width == 6'd63);

  // column-major walk: step down the kernel column, then move to the next column
  assign nkr = (kr == r_hi) ? r_lo : kr + 2'd1;
  assign nkc = (kr == r_hi) ? kc + 2'd1 : kc;

  assign nx = cnt_width + 6'd1;
  assign ny = (cnt_width == 6'd63) ? cnt_length + 6'd1 : cnt_length;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      iaddr      <= '0;
      pi0        <= '0;
      pi1        <= '0;
      pi2        <= '0;
      cnt_pixel  <= '0;
      cnt_length <= '0;
      cnt_width  <= '0;
      conv_valid <= 1'b0;
      caddr      <= '0;
      done       <= 1'b0;
      kr         <= 2'd1;
      kc         <= 2'd1;
      sel        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          conv_valid <= 1'b0;
          done       <= 1'b0;
          busy       <= 1'b0;
          if (ready && !busy) begin
            state      <= FETCH;
            busy       <= 1'b1;
            cnt_length <= '0;
            cnt_width  <= '0;
            kr         <= 2'd1;
            kc         <= 2'd1;
            iaddr      <= '0;
            cnt_pixel  <= '0;
            sel        <= 2'd0;
          end
        end
        FETCH: begin
          conv_valid <= 1'b0;
          done       <= 1'b0;
          case (sel)
            2'd0:    pi0 <= idata;
            2'd1:    pi1 <= idata;
            default: pi2 <= idata;
          endcase
          sel       <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          cnt_pixel <= cnt_pixel + 4'd1;
          if (last_pix) begin
            state <= HOLD;
          end else begin
            kr    <= nkr;
            kc    <= nkc;
            iaddr <= addr_of(cnt_length, cnt_width, nkr, nkc);
          end
        end
        HOLD: begin
          conv_valid <= 1'b1;
          caddr      <= {cnt_length, cnt_width};
          cnt_pixel  <= '0;
          sel        <= 2'd0;
          if (last_win) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state      <= FETCH;
            cnt_length <= ny;
            cnt_width  <= nx;
            kr         <= (ny == 6'd0) ? 2'd1 : 2'd0;
            kc         <= (nx == 6'd0) ? 2'd1 : 2'd0;
            iaddr      <= addr_of(ny, nx, (ny == 6'd0) ? 2'd1 : 2'd0,
                                  (nx == 6'd0) ? 2'd1 : 2'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_fetch.sv
// Self-checking bench for conv_fetch: random ROM contents and random ready noise,
// checked cycle by cycle against a window-list reference model.
module tb_conv_fetch;
  logic        clk = 1'b0;
  logic        reset, ready;
  logic        busy, flag_corner, flag_upbot, flag_lfri, conv_valid, done;
  logic [11:0] iaddr, caddr;
  logic [15:0] idata, pi0, pi1, pi2;
  logic [3:0]  cnt_pixel;
  logic [5:0]  cnt_length, cnt_width;

  logic [15:0] rom [4096];
  int          mpi [3];
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt;

  assign idata = rom[iaddr];

  always #5 clk = ~clk;

  conv_fetch #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .pi0(pi0), .pi1(pi1), .pi2(pi2), .cnt_pixel(cnt_pixel), .cnt_length(cnt_length),
    .cnt_width(cnt_width), .flag_corner(flag_corner), .flag_upbot(flag_upbot),
    .flag_lfri(flag_lfri), .conv_valid(conv_valid), .caddr(caddr), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_conv_valid", conv_valid, 0);
    check("rst_done", done, 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_pi0", pi0, 0);
    check("rst_pi1", pi1, 0);
    check("rst_pi2", pi2, 0);
    check("rst_cnt_pixel", cnt_pixel, 0);
    check("rst_cnt_length", cnt_length, 0);
    check("rst_cnt_width", cnt_width, 0);
    check("rst_caddr", caddr, 0);
    check("rst_flag_corner", flag_corner, 1);
    check("rst_flag_upbot", flag_upbot, 0);
    check("rst_flag_lfri", flag_lfri, 0);
  endtask

  // position, count, flags, pixel slots and busy for one cycle of window (y,x)
  task automatic check_window(input int y, input int x, input int k);
    bit er, ec;
    er = (y == 0) || (y == 63);
    ec = (x == 0) || (x == 63);
    check("cnt_length", cnt_length, y);
    check("cnt_width", cnt_width, x);
    check("cnt_pixel", cnt_pixel, k);
    check("flag_corner", flag_corner, er && ec);
    check("flag_upbot", flag_upbot, er && !ec);
    check("flag_lfri", flag_lfri, ec && !er);
    check("pi0", pi0, mpi[0]);
    check("pi1", pi1, mpi[1]);
    check("pi2", pi2, mpi[2]);
    check("busy", busy, 1);
    if (busy === 1'b1) busy_cnt++;
  endtask

  // Start a frame and follow it; when (ry,rx,rk) is reached, reset mid-frame instead.
  task automatic run_frame(input int ry, input int rx, input int rk);
    bit have_prev;
    int prev;
    int q[$];
    have_prev = 0;
    prev      = 0;
    busy_cnt  = 0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        q.delete();
        for (int dx = -1; dx <= 1; dx++)
          for (int dy = -1; dy <= 1; dy++)
            if (y + dy >= 0 && y + dy < 64 && x + dx >= 0 && x + dx < 64)
              q.push_back((y + dy) * 64 + (x + dx));
        for (int k = 0; k < q.size(); k++) begin
          check_window(y, x, k);
          check("iaddr", iaddr, q[k]);
          check("conv_valid", conv_valid, (k == 0) && have_prev);
          check("done", done, 0);
          if (k == 0 && have_prev) check("caddr", caddr, prev);
          if (y == ry && x == rx && k == rk) begin
            reset = 1'b1;
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            reset = 1'b0;
            ready = 1'b0;
            mpi[0] = 0; mpi[1] = 0; mpi[2] = 0;
            check_reset_vals();
            return;
          end
          mpi[k % 3] = rom[q[k]];
          ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        check_window(y, x, q.size());
        check("hold_conv_valid", conv_valid, 0);
        ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        have_prev = 1;
        prev = y * 64 + x;
      end
    end
    check("final_conv_valid", conv_valid, 1);
    check("final_done", done, 1);
    check("final_caddr", caddr, 4095);
    check("final_busy", busy, 1);
    if (busy === 1'b1) busy_cnt++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("after_busy", busy, 0);
    check("after_conv_valid", conv_valid, 0);
    check("after_done", done, 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("busy_cycles", busy_cnt, 40197);
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    for (int a = 0; a < 4096; a++) rom[a] = 16'($urandom);
    for (int i = 0; i < 3; i++) mpi[i] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_reset_vals();
      @(negedge clk);
    end
    run_frame(-1, -1, -1);
    run_frame(10, 10, 5);
    @(negedge clk);
    check_reset_vals();
    run_frame(1, int'($urandom_range(0, 63)), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
